// File: rtl/mc_control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : mips_ctrl_pkg                                              |
// | Purpose  : Opcode/funct constants, state codes, datapath select       |
// |            encodings and the control-word layout for the multicycle   |
// |            MIPS controller, ALU control and datapath muxes.           |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mips_ctrl_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Funct value that turns an R-type into JR
  localparam logic [5:0] FN_JR   = 6'b001000;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // Controller state codes; 13..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JR        = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  // Instruction class produced by the opcode decoder
  typedef enum logic [2:0] {
    IC_LW      = 3'd0,
    IC_SW      = 3'd1,
    IC_R       = 3'd2,
    IC_JR      = 3'd3,
    IC_BEQ     = 3'd4,
    IC_J       = 3'd5,
    IC_ADDI    = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_t;

  // Full set of datapath controls driven in one cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: mc_control_if                                              |
// | Purpose  : Bundles the instruction fields, memory handshake and all   |
// |            datapath controls between controller and datapath.         |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface mc_control_if #(
  parameter int OP_W = 6,
  parameter int FN_W = 6,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [FN_W-1:0] func;
  logic            mem_ready;
  logic            pc_write;
  logic            pc_write_cond;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_source;
  logic            illegal_op;
  logic [ST_W-1:0] state;

  // Controller side
  modport master (
    input  opcode, func, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  // Datapath / memory side
  modport slave (
    output opcode, func, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_opdecode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_opdecode                                                |
// | Purpose  : Combinational opcode/funct to instruction-class decoder.   |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mc_opdecode
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] func,
  output iclass_t         iclass
);

  // Classify the instruction; any R-type funct other than JR executes on the ALU
  always_comb begin
    iclass = IC_ILLEGAL;
    if (opcode == OP_W'(OP_R))
      iclass = (func == FN_W'(FN_JR)) ? IC_JR : IC_R;
    else if (opcode == OP_W'(OP_LW))
      iclass = IC_LW;
    else if (opcode == OP_W'(OP_SW))
      iclass = IC_SW;
    else if (opcode == OP_W'(OP_BEQ))
      iclass = IC_BEQ;
    else if (opcode == OP_W'(OP_J))
      iclass = IC_J;
    else if (opcode == OP_W'(OP_ADDI))
      iclass = IC_ADDI;
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_control                                                 |
// | Purpose  : Multicycle main control FSM: fetch, decode, execute,       |
// |            memory and write-back sequencing with memory-ready stall.  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6,
  parameter int ST_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_if.master  bus
);

  state_t  state_q;
  state_t  state_d;
  iclass_t iclass;
  ctrl_t   ctrl;
  ctrl_t   ctrl_out;

  mc_opdecode #(
    .OP_W (OP_W),
    .FN_W (FN_W)
  ) u_opdecode (
    .opcode (bus.opcode),
    .func   (bus.func),
    .iclass (iclass)
  );

  // State register; reset wins over any pending memory completion
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  // Next-state selection and per-state control word
  always_comb begin
    state_d = S_FETCH;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (iclass)
          IC_LW, IC_SW: state_d = S_MEM_ADDR;
          IC_R:         state_d = S_R_EXEC;
          IC_JR:        state_d = S_JR;
          IC_BEQ:       state_d = S_BRANCH;
          IC_J:         state_d = S_JUMP;
          IC_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (iclass == IC_SW)
          state_d = S_MEM_WR;
        else if (iclass == IC_LW)
          state_d = S_MEM_RD;
        else
          state_d = S_FETCH;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        state_d        = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = S_FETCH;
      end
      S_JR: begin
        // PC takes rs data directly, no adder in the path
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_RS;
        state_d        = S_FETCH;
      end
      default: begin
        ctrl.illegal_op = 1'b1;
        state_d         = S_FETCH;
      end
    endcase
  end

  // All strobes are forced low while reset is held, abandoning any access
  assign ctrl_out = reset ? '0 : ctrl;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.iord          = ctrl_out.iord;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.illegal_op    = ctrl_out.illegal_op;
  assign bus.state         = ST_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mc_control                                              |
// | Purpose  : Self-checking bench for mc_control; an instruction-level   |
// |            model expands each instruction into expected cycles.       |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mc_control;

  logic clk;
  logic reset;

  mc_control_if #(.OP_W(6), .FN_W(6), .ST_W(4)) bus ();

  mc_control #(.OP_W(6), .FN_W(6), .ST_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected record per cycle: {state[3:0], control vector[16:0]}
  logic [20:0] exp_q[$];
  logic [3:0]  trace[$];

  // Control vector field order:
  // pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg
  // reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2] illegal_op
  function automatic logic [16:0] ov(
    input logic pw, input logic pwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rd,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] ps, input logic ill);
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.illegal_op};
  endfunction

  // Instruction class: 0 LW, 1 SW, 2 R, 3 JR, 4 BEQ, 5 J, 6 ADDI, 7 illegal
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? 3 : 2;
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000100: return 4;
      6'b000010: return 5;
      6'b001000: return 6;
      default:   return 7;
    endcase
  endfunction

  // One clock of stimulus plus the expectation for that cycle
  task automatic step(input logic rst_v, input logic rdy,
                      input logic [3:0] st, input logic [16:0] o);
    reset         = rst_v;
    bus.mem_ready = rdy;
    exp_q.push_back({st, o});
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its cycle-by-cycle expectations
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fwait, input int mwait);
    int cls;
    cls = classify(op, fn);
    bus.opcode = op;
    bus.func   = fn;
    for (int i = 0; i < fwait; i++)
      step(1'b0, 1'b0, 4'd0, ov(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
    step(1'b0, 1'b1, 4'd0, ov(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0));
    step(1'b0, 1'b1, 4'd1, ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,cls == 7));
    case (cls)
      0: begin
        step(1'b0, 1'b1, 4'd2, ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        for (int i = 0; i < mwait; i++)
          step(1'b0, 1'b0, 4'd3, ov(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        step(1'b0, 1'b1, 4'd3, ov(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        step(1'b0, 1'b1, 4'd4, ov(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0));
      end
      1: begin
        step(1'b0, 1'b1, 4'd2, ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        for (int i = 0; i < mwait; i++)
          step(1'b0, 1'b0, 4'd5, ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        step(1'b0, 1'b1, 4'd5, ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
      end
      2: begin
        step(1'b0, 1'b1, 4'd6, ov(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
        step(1'b0, 1'b1, 4'd7, ov(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
      end
      3: step(1'b0, 1'b1, 4'd10, ov(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,0));
      4: step(1'b0, 1'b1, 4'd8,  ov(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0));
      5: step(1'b0, 1'b1, 4'd9,  ov(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0));
      6: begin
        step(1'b0, 1'b1, 4'd11, ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        step(1'b0, 1'b1, 4'd12, ov(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
      end
      default: ;
    endcase
  endtask

  // Compare the observed state trace against a hand-written nibble list
  task automatic check_trace(input string name, input logic [63:0] exp_p, input int n);
    logic [63:0] got_p;
    got_p = '0;
    foreach (trace[i]) got_p = {got_p[59:0], trace[i]};
    checks++;
    if (trace.size() != n || got_p != exp_p) begin
      failures++;
      $display("FAIL trace_%s got=%h (len %0d) exp=%h (len %0d)",
               name, got_p, trace.size(), exp_p, n);
    end
    trace.delete();
  endtask

  // Single compare process: every queued cycle is checked mid-cycle
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        trace.push_back(bus.state);
        checks++;
        if (bus.state !== e[20:17]) begin
          failures++;
          $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, bus.state, e[20:17]);
        end
        checks++;
        if (dut_vec() !== e[16:0]) begin
          failures++;
          $display("FAIL ctrl cyc=%0d state=%0d got=%b exp=%b", cyc, bus.state, dut_vec(), e[16:0]);
        end
        checks++;
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
          failures++;
          $display("FAIL rd_wr_excl cyc=%0d got=11 exp=not both", cyc);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    reset      = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000000;
    bus.func   = 6'b100000;
    @(posedge clk);
    #1;
    // Reset held 3 cycles with mem_ready high: FETCH, everything low
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd0, 17'd0);
    check_trace("reset", 64'h000, 3);

    run_instr(6'b000000, 6'b100000, 0, 0);   // ADD
    check_trace("add", 64'h0167, 4);
    run_instr(6'b100011, 6'b000000, 1, 2);   // LW, fetch wait 1, mem wait 2
    check_trace("lw", 64'h00123334, 8);
    run_instr(6'b101011, 6'b000000, 0, 1);   // SW, mem wait 1
    check_trace("sw", 64'h01255, 5);
    run_instr(6'b001000, 6'b000000, 0, 0);   // ADDI
    check_trace("addi", 64'h01bc, 4);
    run_instr(6'b000000, 6'b001000, 0, 0);   // JR
    check_trace("jr", 64'h01a, 3);
    run_instr(6'b000100, 6'b000000, 0, 0);   // BEQ
    check_trace("beq", 64'h018, 3);
    run_instr(6'b000010, 6'b000000, 0, 0);   // J
    check_trace("j", 64'h019, 3);
    run_instr(6'b111111, 6'b000000, 0, 0);   // illegal opcode
    check_trace("ill", 64'h01, 2);
    run_instr(6'b000001, 6'b100000, 2, 0);   // another illegal, after fetch stall
    check_trace("ill2", 64'h0001, 4);

    // Reset during an SW memory wait: strobes drop in the reset cycle
    bus.opcode = 6'b101011;
    step(1'b0, 1'b1, 4'd0, ov(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0));
    step(1'b0, 1'b1, 4'd1, ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
    step(1'b0, 1'b1, 4'd2, ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
    step(1'b0, 1'b0, 4'd5, ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    step(1'b1, 1'b1, 4'd5, 17'd0);
    step(1'b0, 1'b0, 4'd0, ov(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
    check_trace("sw_rst", 64'h012550, 6);

    run_instr(6'b000000, 6'b100010, 0, 0);   // SUB after recovery
    check_trace("sub", 64'h0167, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
